// File: rtl/spinner_pkg.sv
// Shared types for the multi-channel spinner emulator.
// Analog sample format and accumulator width helper.
package spinner_pkg;

    typedef logic signed [7:0] delta_t;

    typedef struct packed {
        logic   toggle;
        delta_t delta;
    } sample_t;

    typedef enum logic {
        SRC_SPIN  = 1'b0,
        SRC_MOUSE = 1'b1
    } src_t;

    function automatic int acc_w(input int out_w, input int ashift);
        return out_w + ashift;
    endfunction

endpackage

// File: rtl/spinner_chan.sv
// One rotary channel: wrapping accumulator, button ramp, spinner toggle copy.
// Ports: clk, reset, tick, plus/minus/fast/invert, spin_tog, ana_valid/ana_delta,
//        spin_flip (raw spinner sample seen), pos (integer part of acc).
module spinner_chan
    import spinner_pkg::*;
#(
    parameter int OUT_W    = 8,
    parameter int ASHIFT   = 0,
    parameter int STEP_MIN = 1,
    parameter int STEP_MAX = 4,
    parameter int RAMP     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             plus,
    input  logic             minus,
    input  logic             fast,
    input  logic             invert,
    input  logic             spin_tog,
    input  logic             ana_valid,
    input  delta_t           ana_delta,
    output logic             spin_flip,
    output logic [OUT_W-1:0] pos
);

    localparam int AW = acc_w(OUT_W, ASHIFT);
    localparam int SW = $clog2(STEP_MAX + 1);
    localparam int HW = (RAMP > 1) ? $clog2(RAMP) : 1;

    localparam logic [SW-1:0] S_MIN  = SW'(STEP_MIN);
    localparam logic [SW-1:0] S_MAX  = SW'(STEP_MAX);
    localparam logic [HW-1:0] H_LAST = HW'(RAMP - 1);

    logic [AW-1:0] acc;
    logic [SW-1:0] step, step_d;
    logic [HW-1:0] hold_cnt, hold_d;
    logic          tog_q;

    logic          up, dn;
    logic [SW-1:0] app;
    logic [AW-1:0] mag, dig, ana, tot;

    assign spin_flip = spin_tog ^ tog_q;
    assign pos       = acc[AW-1:ASHIFT];

    always_comb begin
        up  = plus & ~minus;
        dn  = minus & ~plus;
        app = fast ? S_MAX : step;
        mag = AW'(app) << ASHIFT;
        dig = '0;
        if (tick && up) begin
            dig = mag;
        end else if (tick && dn) begin
            dig = -mag;
        end
        // sized cast of a signed delta sign-extends into the accumulator
        ana = ana_valid ? AW'(ana_delta) : '0;
        tot = dig + ana;
        if (invert) begin
            tot = -tot;
        end

        step_d = step;
        hold_d = hold_cnt;
        if (tick) begin
            if (up || dn) begin
                if (hold_cnt == H_LAST) begin
                    hold_d = '0;
                    step_d = (step >= S_MAX) ? S_MAX : step + 1'b1;
                end else begin
                    hold_d = hold_cnt + 1'b1;
                end
            end else begin
                step_d = S_MIN;
                hold_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            step     <= S_MIN;
            hold_cnt <= '0;
            tog_q    <= spin_tog;
        end else begin
            acc      <= acc + tot;
            step     <= step_d;
            hold_cnt <= hold_d;
            tog_q    <= spin_tog;
        end
    end

endmodule

// File: rtl/spinner_mc.sv
// Multi-channel rotary-control emulator for paddle/dial inputs.
// Ports: clk, reset, strobe, minus/plus/fast/invert[CH], spin_in[CH*9],
//        mouse_in[9], spin_out[CH*OUT_W], src_mouse (ch0 source select).
module spinner_mc
    import spinner_pkg::*;
#(
    parameter int CH       = 2,
    parameter int OUT_W    = 8,
    parameter int ASHIFT   = 0,
    parameter int STEP_MIN = 1,
    parameter int STEP_MAX = 4,
    parameter int RAMP     = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                strobe,
    input  logic [CH-1:0]       minus,
    input  logic [CH-1:0]       plus,
    input  logic [CH-1:0]       fast,
    input  logic [CH-1:0]       invert,
    input  logic [CH*9-1:0]     spin_in,
    input  logic [8:0]          mouse_in,
    output logic [CH*OUT_W-1:0] spin_out,
    output logic                src_mouse
);

    sample_t       mouse_s;
    logic          strobe_q;
    logic          mouse_tog_q;
    logic          tick;
    logic          mouse_flip;
    logic [CH-1:0] spin_flip;
    src_t          src, src_d;

    assign mouse_s    = sample_t'(mouse_in);
    assign tick       = strobe & ~strobe_q;
    assign mouse_flip = mouse_s.toggle ^ mouse_tog_q;
    assign src_mouse  = (src == SRC_MOUSE);

    // spinner activity on channel 0 overrides a same-cycle mouse event
    always_comb begin
        src_d = src;
        if (spin_flip[0]) begin
            src_d = SRC_SPIN;
        end else if (mouse_flip) begin
            src_d = SRC_MOUSE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src         <= SRC_SPIN;
            strobe_q    <= strobe;
            mouse_tog_q <= mouse_s.toggle;
        end else begin
            src         <= src_d;
            strobe_q    <= strobe;
            mouse_tog_q <= mouse_s.toggle;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        sample_t smp;
        logic    ana_valid;
        delta_t  ana_delta;

        assign smp = sample_t'(spin_in[g*9 +: 9]);

        if (g == 0) begin : g_arb
            assign ana_valid = (src_d == SRC_MOUSE) ? mouse_flip : spin_flip[0];
            assign ana_delta = (src_d == SRC_MOUSE) ? mouse_s.delta : smp.delta;
        end else begin : g_plain
            assign ana_valid = spin_flip[g];
            assign ana_delta = smp.delta;
        end

        spinner_chan #(
            .OUT_W    (OUT_W),
            .ASHIFT   (ASHIFT),
            .STEP_MIN (STEP_MIN),
            .STEP_MAX (STEP_MAX),
            .RAMP     (RAMP)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .plus      (plus[g]),
            .minus     (minus[g]),
            .fast      (fast[g]),
            .invert    (invert[g]),
            .spin_tog  (smp.toggle),
            .ana_valid (ana_valid),
            .ana_delta (ana_delta),
            .spin_flip (spin_flip[g]),
            .pos       (spin_out[g*OUT_W +: OUT_W])
        );
    end

endmodule

// File: tb/tb_spinner_mc.sv
// Directed bench for spinner_mc: ramp, wrap, analog, arbitration, reset.
// A second instance with ASHIFT=2 covers fractional analog scaling.
module tb_spinner_mc;

    logic        clk;
    logic        reset;
    logic        strobe;
    logic [1:0]  minus, plus, fast, invert;
    logic [17:0] spin_in;
    logic [8:0]  mouse_in;
    logic [15:0] spin_out;
    logic        src_mouse;

    logic        z_strobe;
    logic [0:0]  z_minus, z_plus, z_fast, z_invert;
    logic [8:0]  spin2;
    logic [8:0]  z_mouse;
    logic [7:0]  out2;
    logic        src2;

    int n_cmp = 0;
    int n_bad = 0;

    spinner_mc dut (
        .clk       (clk),
        .reset     (reset),
        .strobe    (strobe),
        .minus     (minus),
        .plus      (plus),
        .fast      (fast),
        .invert    (invert),
        .spin_in   (spin_in),
        .mouse_in  (mouse_in),
        .spin_out  (spin_out),
        .src_mouse (src_mouse)
    );

    spinner_mc #(.CH(1), .ASHIFT(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .strobe    (z_strobe),
        .minus     (z_minus),
        .plus      (z_plus),
        .fast      (z_fast),
        .invert    (z_invert),
        .spin_in   (spin2),
        .mouse_in  (z_mouse),
        .spin_out  (out2),
        .src_mouse (src2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stb;
        logic [1:0]  pl;
        logic [1:0]  inv;
        logic [17:0] spin;
        logic [8:0]  mouse;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic        esrc;
    } vec_t;

    vec_t tbl[13];
    int   ramp_exp[3];
    int   ash_exp[4];

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic tick_once;
        strobe = 1'b1;
        cyc();
        strobe = 1'b0;
        cyc();
    endtask

    initial begin
        // stb pl inv spin={t1,d1,t0,d0} mouse={t,d} e0 e1 esrc
        tbl[0]  = '{1'b0, 2'b00, 2'b00, {1'b0, 8'h00, 1'b1, 8'h05}, {1'b0, 8'h00}, 8'd5,  8'd0,   1'b0};
        tbl[1]  = '{1'b0, 2'b00, 2'b00, {1'b0, 8'h00, 1'b0, 8'hFD}, {1'b0, 8'h00}, 8'd2,  8'd0,   1'b0};
        tbl[2]  = '{1'b0, 2'b00, 2'b00, {1'b0, 8'h00, 1'b0, 8'h7F}, {1'b0, 8'h00}, 8'd2,  8'd0,   1'b0};
        tbl[3]  = '{1'b0, 2'b00, 2'b00, {1'b1, 8'h80, 1'b0, 8'h7F}, {1'b0, 8'h00}, 8'd2,  8'd128, 1'b0};
        tbl[4]  = '{1'b0, 2'b00, 2'b00, {1'b1, 8'h80, 1'b0, 8'h7F}, {1'b1, 8'h0A}, 8'd12, 8'd128, 1'b1};
        tbl[5]  = '{1'b0, 2'b00, 2'b00, {1'b1, 8'h80, 1'b1, 8'h03}, {1'b0, 8'h07}, 8'd15, 8'd128, 1'b0};
        tbl[6]  = '{1'b1, 2'b01, 2'b00, {1'b1, 8'h80, 1'b1, 8'h03}, {1'b0, 8'h07}, 8'd16, 8'd128, 1'b0};
        tbl[7]  = '{1'b0, 2'b00, 2'b00, {1'b1, 8'h80, 1'b1, 8'h03}, {1'b0, 8'h07}, 8'd16, 8'd128, 1'b0};
        tbl[8]  = '{1'b1, 2'b01, 2'b00, {1'b1, 8'h80, 1'b1, 8'h03}, {1'b1, 8'h05}, 8'd22, 8'd128, 1'b1};
        tbl[9]  = '{1'b0, 2'b00, 2'b00, {1'b1, 8'h80, 1'b1, 8'h44}, {1'b1, 8'h05}, 8'd22, 8'd128, 1'b1};
        tbl[10] = '{1'b0, 2'b00, 2'b01, {1'b1, 8'h80, 1'b0, 8'h04}, {1'b1, 8'h05}, 8'd18, 8'd128, 1'b0};
        tbl[11] = '{1'b0, 2'b00, 2'b01, {1'b1, 8'h80, 1'b0, 8'h04}, {1'b0, 8'h03}, 8'd15, 8'd128, 1'b1};
        tbl[12] = '{1'b1, 2'b10, 2'b00, {1'b0, 8'h02, 1'b0, 8'h04}, {1'b0, 8'h03}, 8'd15, 8'd131, 1'b1};
        ramp_exp = '{5, 15, 30};
        ash_exp  = '{0, 0, 0, 1};

        reset    = 1'b1;
        strobe   = 1'b0;
        minus    = '0;
        plus     = '0;
        fast     = '0;
        invert   = '0;
        spin_in  = '0;
        mouse_in = '0;
        z_strobe = 1'b0;
        z_minus  = '0;
        z_plus   = '0;
        z_fast   = '0;
        z_invert = '0;
        z_mouse  = '0;
        spin2    = '0;

        do_reset();
        chk("rst_out0", spin_out[7:0], 0);
        chk("rst_out1", spin_out[15:8], 0);
        chk("rst_src", src_mouse, 0);
        chk("rst_out2", out2, 0);

        // ramp on channel 0
        plus = 2'b01;
        for (int i = 1; i <= 15; i++) begin
            tick_once();
            if (i % 5 == 0) chk("ramp", spin_out[7:0], ramp_exp[i/5-1]);
        end
        tick_once();
        chk("ramp_max1", spin_out[7:0], 34);
        tick_once();
        chk("ramp_max2", spin_out[7:0], 38);
        plus = 2'b00;
        tick_once();
        chk("idle_tick", spin_out[7:0], 38);
        plus = 2'b01;
        tick_once();
        chk("step_min", spin_out[7:0], 39);
        strobe = 1'b1;
        cyc();
        chk("held_strobe_a", spin_out[7:0], 40);
        cyc();
        cyc();
        chk("held_strobe_b", spin_out[7:0], 40);
        strobe = 1'b0;
        cyc();
        chk("ch1_quiet", spin_out[15:8], 0);

        // reset mid-hold drops the ramped step
        plus = 2'b00;
        do_reset();
        plus = 2'b01;
        for (int i = 0; i < 7; i++) tick_once();
        chk("hold_pre_rst", spin_out[7:0], 9);
        do_reset();
        chk("hold_rst", spin_out[7:0], 0);
        tick_once();
        chk("hold_post_rst", spin_out[7:0], 1);

        // wrap with fast, inverted minus on channel 1
        plus = 2'b00;
        do_reset();
        spin_in[8:0] = {1'b1, 8'hFE};
        cyc();
        chk("set_254", spin_out[7:0], 254);
        plus = 2'b01;
        fast = 2'b01;
        tick_once();
        chk("fast_wrap", spin_out[7:0], 2);
        plus   = 2'b00;
        fast   = 2'b00;
        minus  = 2'b10;
        invert = 2'b10;
        for (int i = 0; i < 3; i++) tick_once();
        chk("inv_minus", spin_out[15:8], 3);
        chk("inv_ch0_hold", spin_out[7:0], 2);
        minus  = 2'b00;
        invert = 2'b00;

        // table: analog samples, arbitration, combined adds
        spin_in  = '0;
        mouse_in = '0;
        do_reset();
        foreach (tbl[k]) begin
            strobe   = tbl[k].stb;
            plus     = tbl[k].pl;
            invert   = tbl[k].inv;
            spin_in  = tbl[k].spin;
            mouse_in = tbl[k].mouse;
            cyc();
            chk($sformatf("vec%0d_out0", k), spin_out[7:0], tbl[k].e0);
            chk($sformatf("vec%0d_out1", k), spin_out[15:8], tbl[k].e1);
            chk($sformatf("vec%0d_src", k), src_mouse, tbl[k].esrc);
        end
        strobe = 1'b0;
        plus   = 2'b00;
        invert = 2'b00;
        cyc();

        // fractional scaling, ASHIFT=2
        for (int k = 0; k < 4; k++) begin
            spin2 = {~spin2[8], 8'h01};
            cyc();
            chk($sformatf("ashift%0d", k), out2, ash_exp[k]);
        end

        // reset while every edge detector sees a change
        plus     = 2'b01;
        strobe   = 1'b1;
        spin_in  = spin_in ^ 18'h20100;
        mouse_in = mouse_in ^ 9'h100;
        spin2    = spin2 ^ 9'h100;
        do_reset();
        cyc();
        chk("rel_out0", spin_out[7:0], 0);
        chk("rel_out1", spin_out[15:8], 0);
        chk("rel_src", src_mouse, 0);
        cyc();
        cyc();
        chk("rel_out0_b", spin_out[7:0], 0);
        chk("rel_out2", out2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spinner_mc.md
# spinner_mc

Multi-channel rotary-control emulator feeding the game core's paddle/dial input ports. Each channel keeps a wrapping position counter that digital buttons (with ramped acceleration), a hardware spinner and, on channel 0, a PS/2 mouse advance. It generalises the single-channel spinner in channel count, output width and fractional analog scaling. It adds step acceleration, per-channel inversion and arbitrated mouse/spinner source selection.

## Interface

Parameters:
- CH, 2, number of channels
- OUT_W, 8, position counter width per channel
- ASHIFT, 0, analog fractional bits; analog delta divided by 2^ASHIFT with remainder kept
- STEP_MIN, 1, digital step after release
- STEP_MAX, 4, digital step ceiling, and step used while `fast` is held
- RAMP, 5, held strobes per step increment

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- strobe  in  1  frame strobe; rising edge is the digital update tick
- minus  in  CH  per-channel decrement button
- plus  in  CH  per-channel increment button
- fast  in  CH  per-channel fast modifier
- invert  in  CH  per-channel negate all deltas
- spin_in  in  CH*9  per channel {toggle, signed 8-bit delta}; toggle flip marks a new sample
- mouse_in  in  9  {toggle, signed 8-bit X delta}, channel 0 only
- spin_out  out  CH*OUT_W  per-channel position, channel 0 in LSBs
- src_mouse  out  1  1 = channel 0 analog source is the mouse

## Operation

- Per-channel accumulator `acc` is OUT_W+ASHIFT bits. spin_out = acc[OUT_W+ASHIFT-1:ASHIFT]. All arithmetic is modulo 2^(OUT_W+ASHIFT), so it wraps with no saturation.
- Strobe tick: strobe=1 and strobe_q=0 at a clock edge.
- Digital direction is +1 if plus&~minus, −1 if minus&~plus, otherwise idle.
- On each tick with a direction, applied step = STEP_MAX if fast, else `step`. Add ±(applied step << ASHIFT).
- Ramp per channel, evaluated on ticks only:
  - held: hold_cnt++; when hold_cnt reaches RAMP, hold_cnt←0 and step←min(step+1, STEP_MAX). The new step takes effect from the next tick.
  - idle: step←STEP_MIN, hold_cnt←0.
- Analog sample: toggle bit differs from its registered copy. Add the sign-extended delta (8 bits extended to OUT_W+ASHIFT bits). The toggle copy updates every cycle.
- Channel 0 source arbitration (`use_mouse` register):
  - mouse toggle flip sets it to 1;
  - spin_in[0] toggle flip clears it to 0;
  - both in the same cycle clear it (spinner wins).
  - Only the selected source's sample is added, evaluated with the updated selection. The unselected source's toggle is still tracked.
- Channels ≥1 ignore mouse_in.
- invert negates the total delta before the add.
- Digital and analog events in the same cycle are summed into a single add.

## Timing

- Reset values: acc=0 (spin_out=0), step=STEP_MIN, hold_cnt=0, src_mouse=0.
- During reset, strobe_q and the toggle copies load the current inputs, so there is no spurious tick or sample on the first cycle after reset.
- Reset mid-hold discards the ramp state.
- Latency: the clock edge that first sees a toggle flip or strobe tick updates acc. spin_out reflects it immediately after that edge (1 cycle from input).
- src_mouse changes on the same edge as the arbitrated sample.
- strobe held high gives exactly one tick.
- Multiple toggle flips on consecutive cycles are each accepted; there is no rate limit.

## Structure

- Package `spinner_pkg`:
  - delta typedef (signed 8-bit);
  - sample struct {toggle, delta};
  - localparam function for the accumulator width.
- Sub-module `spinner_chan`, one per channel in a generate loop, holds acc, ramp state and the toggle copy. Its inputs are the selected analog sample, the tick, and the per-channel buttons.
- Arbitration and strobe edge detection sit in the top module.

## Test plan

- Reset, hold plus[0] for 15 ticks → spin_out[0] after ticks 5/10/15 = 5/15/30. Then 4 per tick. Release, tick with plus → +1.
- Set spin_out[0]=254. Hold plus+fast for 1 tick → 2 (wrap). minus[1]+invert[1] for 3 ticks from 0 → 3.
- Flip spin_in[0] toggle with delta 0x05, then flip with 0xFD → 5 then 2. Change delta without a flip → no change.
- ASHIFT=2 build: four flips of +1 → spin_out 0,0,0,1.
- Mouse flip +10 → src_mouse=1, out 10. Then simultaneous mouse flip +7 and spin_in[0] flip +3 → src_mouse=0, out 13. Same-cycle tick with plus[0] → 14.
- Assert reset while toggles and strobe differ from their copies, then release → outputs 0 and stay 0 with no input change.
